// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the uart transmit FIFO port between two FWFT byte
// requesters. A grant is locked for a whole frame (up to a byte flagged
// last). Grants alternate round-robin. A frame whose requester stalls
// mid-frame is released after pTimeoutCycles empty cycles.
module uart_tx_arbiter #(
    parameter int pTimeoutCycles = 12000
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iReq0Empty,
    input  logic [7:0] iReq0Data,
    input  logic       iReq0Last,
    output logic       oReq0RdEn,
    input  logic       iReq1Empty,
    input  logic [7:0] iReq1Data,
    input  logic       iReq1Last,
    output logic       oReq1RdEn,
    output logic       oTxRdEmpty,
    output logic [7:0] oTxData,
    input  logic       iTxRdEn,
    output logic [1:0] oGrant,
    output logic       oBusy,
    output logic       oTimeoutErr
);

    localparam int TW = $clog2(pTimeoutCycles + 1);
    localparam logic [TW-1:0] TMAX = TW'(pTimeoutCycles);
    localparam logic [TW-1:0] TLIM = TW'(pTimeoutCycles - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state, state_nxt;
    logic          gsel, gsel_nxt;
    logic          prio, prio_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          terr, terr_nxt;

    logic          g_empty;
    logic          g_last;
    logic [7:0]    g_data;
    logic          pop;
    logic          locked;

    // Select the granted requester's FIFO head and qualify the uart pop.
    always_comb begin
        g_empty = gsel ? iReq1Empty : iReq0Empty;
        g_last  = gsel ? iReq1Last  : iReq0Last;
        g_data  = gsel ? iReq1Data  : iReq0Data;
        locked  = (state == LOCK);
        pop     = locked & iTxRdEn & ~g_empty;
    end

    // Combinational pass-through while locked; IDLE presents an empty FIFO.
    always_comb begin
        oTxRdEmpty  = locked ? g_empty : 1'b1;
        oTxData     = locked ? g_data  : 8'h00;
        oReq0RdEn   = pop & ~gsel;
        oReq1RdEn   = pop & gsel;
        oGrant      = locked ? (gsel ? 2'b10 : 2'b01) : 2'b00;
        oBusy       = locked;
        oTimeoutErr = terr;
    end

    // Next-state: grant choice in IDLE, frame end and stall timeout in LOCK.
    always_comb begin
        state_nxt = state;
        gsel_nxt  = gsel;
        prio_nxt  = prio;
        tcnt_nxt  = tcnt;
        terr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!iReq0Empty || !iReq1Empty) begin
                    state_nxt = LOCK;
                    tcnt_nxt  = '0;
                    // Favour the pointer's requester, fall back to the other.
                    gsel_nxt  = (prio ? !iReq1Empty : !iReq0Empty) ? prio : ~prio;
                end
            end
            LOCK: begin
                if (pop) begin
                    // A pop always beats a timeout landing in the same cycle.
                    tcnt_nxt = '0;
                    if (g_last) begin
                        state_nxt = IDLE;
                        prio_nxt  = ~gsel;
                    end
                end else if (g_empty) begin
                    if (tcnt >= TLIM) begin
                        // Drop the lock; remaining bytes form a new frame later.
                        state_nxt = IDLE;
                        prio_nxt  = ~gsel;
                        terr_nxt  = 1'b1;
                        tcnt_nxt  = TMAX;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; reset abandons any frame in progress.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
            gsel  <= 1'b0;
            prio  <= 1'b0;
            tcnt  <= '0;
            terr  <= 1'b0;
        end else begin
            state <= state_nxt;
            gsel  <= gsel_nxt;
            prio  <= prio_nxt;
            tcnt  <= tcnt_nxt;
            terr  <= terr_nxt;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level arbiter that shares the single transmit FIFO port of `uart` between two byte-stream requesters, e.g. the USB FIFO bridge path and the local command/status responder in `top`. It presents itself to `uart` as a first-word-fall-through read FIFO. It locks the grant for a whole frame, which ends on a byte flagged last, so frames never interleave on the serial line. Grants alternate round-robin, and a stalled frame is released by a timeout.

## Interface
- `pTimeoutCycles`, 12000: cycles the granted requester may stay empty mid-frame before its lock is dropped (1 ms at 12 MHz). Legal range is 2 or more.
- `iClk` in 1: system clock, 12 MHz.
- `iRst_n` in 1: asynchronous, active-low reset.
- `iReq0Empty` in 1: requester 0 FIFO empty (FWFT, active-high).
- `iReq0Data` in 8: requester 0 head byte, valid while `iReq0Empty`=0.
- `iReq0Last` in 1: head byte of requester 0 ends its frame, valid with `iReq0Data`.
- `oReq0RdEn` out 1: pop strobe to requester 0.
- `iReq1Empty`, `iReq1Data`[7:0], `iReq1Last`, `oReq1RdEn`: same meanings for requester 1.
- `oTxRdEmpty` out 1: drives `uart.iTxRdEmpty`.
- `oTxData` out 8: drives `uart.iTxData`.
- `iTxRdEn` in 1: from `uart.oTxRdEn`, pops the current byte.
- `oGrant` out 2: one-hot grant, `01`=req0, `10`=req1, `00`=none.
- `oBusy` out 1: a frame is locked.
- `oTimeoutErr` out 1: single-cycle pulse when a lock is dropped by timeout.

## Operation
- Registered state: FSM {IDLE, LOCK}, grant index `gsel`, priority pointer `prio`, timeout counter `tcnt` of width $clog2(pTimeoutCycles+1).
- **IDLE**
  - `oTxRdEmpty`=1 and `oGrant`=00.
  - If either requester is non-empty, go to LOCK next cycle.
  - `gsel` becomes `prio` if that requester is non-empty; otherwise it becomes the other requester.
- **LOCK**, combinational pass-through of the granted requester:
  - `oTxData` = granted data.
  - `oTxRdEmpty` = granted empty.
  - `oReqNRdEn` = `iTxRdEn` & (N==`gsel`) & !`iReqNEmpty`.
  - The non-granted requester is never popped.
- **Frame end**: a pop of a byte with Last=1 moves LOCK to IDLE, and `prio` becomes the requester not just served.
- **Timeout**
  - `tcnt` clears on entry to LOCK and on every pop.
  - `tcnt` increments each LOCK cycle in which the granted requester is empty.
  - When `tcnt` reaches `pTimeoutCycles`: go to IDLE, pulse `oTimeoutErr`, set `prio` to the other requester. The rest of the frame is not flushed; its later bytes start a new frame.
- `tcnt` saturates. It never wraps.
- A pop and the timeout boundary in the same cycle: the pop wins and no error pulse is produced.
- A Last pop with the other requester pending: one IDLE cycle, then LOCK on the other requester.
- Pop attempted while the granted requester is empty: ignored. No RdEn is produced and the counter keeps running.
- Reset, including mid-frame:
  - FSM=IDLE, `gsel`=0, `prio`=0, `tcnt`=0.
  - The frame in progress is abandoned.

## Timing
- Reset values of all outputs:
  - `oGrant`=00, `oBusy`=0, `oTimeoutErr`=0.
  - `oTxRdEmpty`=1, `oTxData`=00.
  - `oReq0RdEn`=0, `oReq1RdEn`=0.
- Reset assertion forces these values immediately, asynchronously. They hold until the first `iClk` edge after `iRst_n` rises.
- Grant latency: a requester going non-empty in IDLE at edge k gives `oGrant`/`oBusy` set after edge k+1. `oTxRdEmpty` can fall in that same cycle.
- Pop path is combinational, with zero added latency. `uart` sees the data exactly as presented by the requester.
- Frame turnaround: the cycle after a Last pop is IDLE, with `oTxRdEmpty`=1. The next grant is visible one cycle later.
- Timeout: the `oTimeoutErr` pulse follows the `pTimeoutCycles`-th consecutive empty LOCK cycle. IDLE is entered in the same cycle as the pulse.
- `oGrant`, `oBusy` and `oTimeoutErr` are registered. The data and empty paths are combinational.

## Test plan
- **Single frame**: req0 supplies 11, 22, 33 (Last on 33); req1 empty. Required: `uart` pops 11, 22, 33 in order; `oGrant`=01 throughout; `oReq1RdEn` never asserts; IDLE after 33.
- **Round-robin**: both requesters hold frames at reset release (req0: A1, A2L; req1: B1L), then req0 gets a second frame C1L. Required line order A1, A2, B1, C1.
- **No interleave**: req1 becomes non-empty while req0 is mid-frame (5 bytes). Required: zero req1 pops until req0's Last pop; req1's first byte follows one IDLE cycle later.
- **Timeout** (`pTimeoutCycles`=16): req0 sends 55 without Last, then stays empty; req1 holds 66L. Required: one `oTimeoutErr` pulse 16 cycles after the last pop, then 66 is sent.
- **Reset mid-frame**: `iRst_n` low during LOCK. Required: `oGrant`=00 and `oTxRdEmpty`=1 with no clock edge; after release, req0 is granted first.
- **UART loopback**: at 115200 baud, req1 sends AAL into `uart` with its Tx looped to Rx. Required: Rx delivers AA; no `oRcvErr`.
